timer_bank: RTL and testbench
=============================

Name: timer_bank

Overview:
- Parametrised multi-channel timer/counter peripheral; next generation of the fixed 3-channel counter in the SoC I/O subsystem.
- Sits behind the MIO bus decoder.
- Each channel has its own prescaler and mode: one-shot, periodic or PWM. Channels are word-addressed registers.
- Provides per-channel sticky interrupt flags with write-1-to-clear, and an aggregated interrupt line to the CPU INT input.

Parameters:
- NUM_CH, 3: number of timer channels, 1..7.
- WIDTH, 32: counter width in bits, 8..32. Register reads are zero-extended to 32 bits.
- PRESC_W, 8: prescaler field width in bits, 1..16.
- ADDR_W, 8: byte-address width. Requires (NUM_CH+1)*32 <= 2^ADDR_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- we  in  1  bus write strobe, one cycle per write.
- addr  in  ADDR_W  byte address; bits [1:0] ignored.
- wdata  in  32  bus write data.
- rdata  out  32  registered read data.
- irq  out  1  OR over channels of (flag & ie).
- ch_irq  out  NUM_CH  per-channel flag & ie.
- pwm_out  out  NUM_CH  per-channel PWM/level output.

Behaviour:
- Addressing: word index w = addr[ADDR_W-1:2]; ch = w[.. :3]; reg = w[2:0].
- Channel registers, for ch < NUM_CH:
  - reg 0 CTRL: [0] en, [2:1] mode (0 one-shot, 1 periodic, 2 PWM, 3 hold), [3] ie, [8+PRESC_W-1:8] presc.
  - reg 1 LOAD.
  - reg 2 COUNT: readable; writable, loads the counter directly.
  - reg 3 CMP.
  - reg 4 CAP: only with the optional feature.
- Global register, ch == NUM_CH, reg 0: STATUS, flags[NUM_CH-1:0]. Write 1 clears the bit.
- Unmapped addresses read 0; writes to them are ignored.
- Read latency: rdata is registered and valid on the cycle after addr is presented. Reads have no side effects.
- Reset: all registers 0, all flags 0, rdata = 0, pwm_out = 0, irq = 0, all prescaler counters 0.
- Prescaler: a per-channel counter counts 0..presc and emits a one-cycle tick at wrap. With presc = 0 a tick occurs every clock. The prescaler runs only while en = 1.
- Enable: a write that sets en from 0 to 1 loads COUNT <= LOAD and clears the prescaler in the same cycle. Clearing en freezes COUNT.
- On each tick with en = 1:
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0, one-shot: flag set, en cleared, COUNT stays 0.
  - COUNT == 0, periodic or PWM: flag set, COUNT <= LOAD.
  - LOAD = 0 in periodic mode: flag set on every tick.
  - Hold mode: no counting, no flags.
- pwm_out:
  - PWM mode: registered (COUNT < CMP) & en. CMP > LOAD gives constant high; CMP = 0 gives constant low.
  - Other modes: 0.
- Simultaneous events:
  - Bus write to COUNT and a tick in the same cycle: the write wins and no flag is set.
  - W1C and a new flag-set in the same cycle: the set wins.
  - Bus write to LOAD takes effect at the next reload and does not disturb the running COUNT.
- Arithmetic: the counter is unsigned WIDTH bits. Bus writes truncate wdata to WIDTH bits.

Optional Feature:
- Macro: TIMER_CAPTURE_EN.
- With the macro defined:
  - Adds input port cap_in[NUM_CH], synchronised by 2 flops per channel.
  - A rising edge of the synchronised signal latches COUNT into CAP and sets flag (regardless of mode) while en = 1.
  - CAP resets to 0 and is read at reg 4.
  - Total latency from cap_in rise to CAP update is 3 clocks.
- Without the macro: no cap_in port; reg 4 reads 0.

Decomposition:
- Package timer_pkg holds:
  - mode encodings: MODE_ONESHOT, MODE_PERIODIC, MODE_PWM, MODE_HOLD;
  - register offsets: REG_CTRL, REG_LOAD, REG_COUNT, REG_CMP, REG_CAP;
  - CTRL bit positions.
- Sub-module timer_channel: one channel containing prescaler, counter, mode logic, PWM and capture.
- Top level: instantiates timer_channel NUM_CH times, plus address decode, STATUS flags and the read mux.

Test Plan:
1. Reset: assert RSTN low mid-count (en = 1, COUNT = 5) -> all reads 0, irq = 0, pwm_out = 0 on the cycle after RSTN rises.
2. One-shot: ch0 LOAD = 3, presc = 0, ie = 1, en = 1 -> STATUS[0] = 1 and irq = 1 four clocks after enable; CTRL.en reads 0; writing STATUS = 1 -> irq = 0 on the next cycle.
3. Periodic with prescaler: ch1 LOAD = 2, presc = 1 -> flag every 6 clocks. Clear flag in the same cycle as the next set -> flag stays 1.
4. PWM: ch2 LOAD = 9, CMP = 3, presc = 0 -> pwm_out[2] high for 3 of every 10 clocks. CMP = 0 -> constant low; CMP = 12 -> constant high.
5. Collision and readback: write COUNT = 7 in the cycle COUNT would reach 0 -> COUNT reads 7, no flag. Read of an unmapped address -> 0, one-cycle latency.
6. With TIMER_CAPTURE_EN: periodic LOAD = 100; pulse cap_in[0] when COUNT = 50 -> CAP reads 47 (3-clock latency), STATUS[0] = 1.

Source files
------------

// File: rtl/timer_pkg.sv
// +-----------------------------------------------------------------------+
// | timer_pkg : shared encodings for the timer_bank peripheral            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package timer_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_PWM      = 2'd2,
        MODE_HOLD     = 2'd3
    } mode_e;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_LOAD   = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_CMP    = 3'd3;
    localparam logic [2:0] REG_CAP    = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd0;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_MODE_LSB  = 1;
    localparam int CTRL_IE        = 3;
    localparam int CTRL_PRESC_LSB = 8;

endpackage

`default_nettype wire

// File: rtl/timer_channel.sv
// +-----------------------------------------------------------------------+
// | timer_channel : one timer with prescaler, counter, modes and PWM.     |
// | Optional capture input when TIMER_CAPTURE_EN is defined.  Rev 1.0     |
// +-----------------------------------------------------------------------+
`default_nettype none

module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        i_wr_ctrl,
    input  logic        i_wr_load,
    input  logic        i_wr_count,
    input  logic        i_wr_cmp,
    input  logic [31:0] i_wdata,
`ifdef TIMER_CAPTURE_EN
    input  logic        i_cap,
`endif
    output logic [31:0] o_ctrl,
    output logic [31:0] o_load,
    output logic [31:0] o_count,
    output logic [31:0] o_cmp,
    output logic [31:0] o_cap,
    output logic        o_ie,
    output logic        o_set,
    output logic        o_pwm
);

    logic               r_en;
    logic               r_ie;
    mode_e              r_mode;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_psc;
    logic [WIDTH-1:0]   r_load;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   r_cmp;
    logic               r_pwm;

    logic               w_enable_rise;
    logic               w_tick;
    logic               w_counting;
    logic               w_expire;
    logic               w_en_nxt;
    logic               w_cap_fire;
    logic               w_unused;
    logic [WIDTH-1:0]   w_count_nxt;

    assign w_enable_rise = i_wr_ctrl && i_wdata[CTRL_EN] && !r_en;
    // >= keeps the prescaler wrapping cleanly if presc is lowered mid-run
    assign w_tick        = r_en && (r_psc >= r_presc);
    assign w_counting    = w_tick && (r_mode != MODE_HOLD);
    assign w_expire      = w_counting && (r_count == '0) && !i_wr_count;

    always_comb begin
        w_count_nxt = r_count;
        w_en_nxt    = r_en;
        if (w_counting) begin
            if (r_count != '0) begin
                w_count_nxt = r_count - WIDTH'(1);
            end else if (r_mode == MODE_ONESHOT) begin
                w_en_nxt = 1'b0;
            end else begin
                w_count_nxt = r_load;
            end
        end
        if (i_wr_ctrl) begin
            w_en_nxt = i_wdata[CTRL_EN];
            if (w_enable_rise) begin
                w_count_nxt = r_load;
            end
        end
        if (i_wr_count) begin
            w_count_nxt = i_wdata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_en    <= 1'b0;
            r_ie    <= 1'b0;
            r_mode  <= MODE_ONESHOT;
            r_presc <= '0;
            r_psc   <= '0;
            r_load  <= '0;
            r_count <= '0;
            r_cmp   <= '0;
            r_pwm   <= 1'b0;
        end else begin
            r_en    <= w_en_nxt;
            r_count <= w_count_nxt;
            if (i_wr_ctrl) begin
                r_mode  <= mode_e'(i_wdata[CTRL_MODE_LSB +: 2]);
                r_ie    <= i_wdata[CTRL_IE];
                r_presc <= i_wdata[CTRL_PRESC_LSB +: PRESC_W];
            end
            if (i_wr_load) begin
                r_load <= i_wdata[WIDTH-1:0];
            end
            if (i_wr_cmp) begin
                r_cmp <= i_wdata[WIDTH-1:0];
            end
            if (w_enable_rise) begin
                r_psc <= '0;
            end else if (r_en) begin
                r_psc <= w_tick ? '0 : r_psc + PRESC_W'(1);
            end
            r_pwm <= (r_mode == MODE_PWM) && r_en && (r_count < r_cmp);
        end
    end

`ifdef TIMER_CAPTURE_EN
    // [0],[1] synchroniser, [2] previous synchronised level for edge detect
    logic [2:0]       r_cap_sync;
    logic [WIDTH-1:0] r_cap;

    assign w_cap_fire = r_en && r_cap_sync[1] && !r_cap_sync[2];

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_cap_sync <= '0;
            r_cap      <= '0;
        end else begin
            r_cap_sync <= {r_cap_sync[1:0], i_cap};
            if (w_cap_fire) begin
                r_cap <= w_count_nxt;
            end
        end
    end

    assign o_cap = 32'(r_cap);
`else
    assign w_cap_fire = 1'b0;
    assign o_cap      = '0;
`endif

    assign o_ctrl   = 32'({r_presc, 4'b0000, r_ie, r_mode, r_en});
    assign o_load   = 32'(r_load);
    assign o_count  = 32'(r_count);
    assign o_cmp    = 32'(r_cmp);
    assign o_ie     = r_ie;
    assign o_set    = w_expire || w_cap_fire;
    assign o_pwm    = r_pwm;
    assign w_unused = ^i_wdata;

endmodule

`default_nettype wire

// File: rtl/timer_bank.sv
// +-----------------------------------------------------------------------+
// | timer_bank : NUM_CH timer channels, STATUS flags (W1C), read mux, IRQ.|
// | Optional capture inputs when TIMER_CAPTURE_EN is defined.  Rev 1.0    |
// +-----------------------------------------------------------------------+
`default_nettype none

module timer_bank
    import timer_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              RSTN,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
`ifdef TIMER_CAPTURE_EN
    input  logic [NUM_CH-1:0] cap_in,
`endif
    output logic [31:0]       rdata,
    output logic              irq,
    output logic [NUM_CH-1:0] ch_irq,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam int c_CH_W = ADDR_W - 5;

    logic [c_CH_W-1:0] w_ch;
    logic [2:0]        w_reg;
    logic              w_status_sel;
    logic              w_unused;
    logic [31:0]       w_rd;
    logic [31:0]       w_ctrl  [NUM_CH];
    logic [31:0]       w_load  [NUM_CH];
    logic [31:0]       w_count [NUM_CH];
    logic [31:0]       w_cmp   [NUM_CH];
    logic [31:0]       w_cap   [NUM_CH];
    logic [NUM_CH-1:0] w_set;
    logic [NUM_CH-1:0] w_ie;
    logic [NUM_CH-1:0] w_clr;
    logic [NUM_CH-1:0] r_flags;

    assign w_ch         = addr[ADDR_W-1:5];
    assign w_reg        = addr[4:2];
    assign w_status_sel = (w_ch == c_CH_W'(NUM_CH)) && (w_reg == REG_STATUS);
    assign w_clr        = (we && w_status_sel) ? wdata[NUM_CH-1:0] : '0;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic w_sel;
            assign w_sel = we && (w_ch == c_CH_W'(i));

            timer_channel #(
                .WIDTH   (WIDTH),
                .PRESC_W (PRESC_W)
            ) u_channel (
                .clk        (clk),
                .RSTN       (RSTN),
                .i_wr_ctrl  (w_sel && (w_reg == REG_CTRL)),
                .i_wr_load  (w_sel && (w_reg == REG_LOAD)),
                .i_wr_count (w_sel && (w_reg == REG_COUNT)),
                .i_wr_cmp   (w_sel && (w_reg == REG_CMP)),
                .i_wdata    (wdata),
`ifdef TIMER_CAPTURE_EN
                .i_cap      (cap_in[i]),
`endif
                .o_ctrl     (w_ctrl[i]),
                .o_load     (w_load[i]),
                .o_count    (w_count[i]),
                .o_cmp      (w_cmp[i]),
                .o_cap      (w_cap[i]),
                .o_ie       (w_ie[i]),
                .o_set      (w_set[i]),
                .o_pwm      (pwm_out[i])
            );
        end
    endgenerate

    always_comb begin
        w_rd = '0;
        if (w_status_sel) begin
            w_rd = 32'(r_flags);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == c_CH_W'(i)) begin
                case (w_reg)
                    REG_CTRL:  w_rd = w_ctrl[i];
                    REG_LOAD:  w_rd = w_load[i];
                    REG_COUNT: w_rd = w_count[i];
                    REG_CMP:   w_rd = w_cmp[i];
                    REG_CAP:   w_rd = w_cap[i];
                    default:   ;
                endcase
            end
        end
    end

    // A new flag-set outranks a same-cycle write-1-to-clear
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            r_flags <= '0;
            rdata   <= '0;
        end else begin
            r_flags <= (r_flags & ~w_clr) | w_set;
            rdata   <= w_rd;
        end
    end

    assign ch_irq   = r_flags & w_ie;
    assign irq      = |ch_irq;
    assign w_unused = ^addr[1:0];

endmodule

`default_nettype wire

// File: tb/tb_timer_bank.sv
// +-----------------------------------------------------------------------+
// | tb_timer_bank : directed scenarios plus randomized single-channel     |
// | runs checked against an arithmetic model of the timer.  Rev 1.0       |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_timer_bank;

    localparam int NUM_CH  = 3;
    localparam int WIDTH   = 32;
    localparam int PRESC_W = 8;
    localparam int ADDR_W  = 8;

    logic              clk   = 1'b0;
    logic              RSTN  = 1'b0;
    logic              we    = 1'b0;
    logic [ADDR_W-1:0] addr  = '0;
    logic [31:0]       wdata = '0;
    logic [31:0]       rdata;
    logic              irq;
    logic [NUM_CH-1:0] ch_irq;
    logic [NUM_CH-1:0] pwm_out;
`ifdef TIMER_CAPTURE_EN
    logic [NUM_CH-1:0] cap_in = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    timer_bank #(
        .NUM_CH  (NUM_CH),
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk     (clk),
        .RSTN    (RSTN),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
`ifdef TIMER_CAPTURE_EN
        .cap_in  (cap_in),
`endif
        .rdata   (rdata),
        .irq     (irq),
        .ch_irq  (ch_irq),
        .pwm_out (pwm_out)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] ra(input int ch, input int r);
        return ADDR_W'(ch * 32 + r * 4);
    endfunction

    function automatic logic [31:0] ctrl_word(input int en, input int mode, input int ie, input int presc);
        return {16'd0, 8'(presc), 4'd0, 1'(ie), 2'(mode), 1'(en)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        addr  = ra(ch, r);
        wdata = d;
        we    = 1'b1;
        step();
        we    = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] d);
        addr = ra(ch, r);
        step();
        d = rdata;
    endtask

    task automatic quiesce();
        for (int c = 0; c < NUM_CH; c++) wr(c, 0, 32'd0);
        wr(NUM_CH, 0, 32'hFF);
    endtask

    // Model: t = clock edges since the enabling write, one tick every presc+1 edges
    function automatic int m_count(input int t, input int mode, input int ld, input int p);
        int k;
        k = t / (p + 1);
        case (mode)
            0:       return (k <= ld) ? ld - k : 0;
            1, 2:    return ld - (k % (ld + 1));
            default: return ld;
        endcase
    endfunction

    function automatic bit m_flag(input int t, input int mode, input int ld, input int p);
        return (mode != 3) && ((t / (p + 1)) >= ld + 1);
    endfunction

    function automatic bit m_en(input int t, input int mode, input int ld, input int p);
        return (mode != 0) || ((t / (p + 1)) < ld + 1);
    endfunction

    function automatic bit m_pwm(input int t, input int mode, input int ld, input int p, input int cmp);
        return (t >= 1) && (mode == 2) && (m_count(t - 1, mode, ld, p) < cmp);
    endfunction

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        int          highs;

        // Reset state
        repeat (2) step();
        RSTN = 1'b1;
        step();
        check_val("reset_rdata", rdata, 32'd0);
        check_val("reset_irq", 32'(irq), 32'd0);
        check_val("reset_pwm", 32'(pwm_out), 32'd0);

        // Reset asserted mid-count
        wr(0, 1, 32'd5);
        wr(0, 0, ctrl_word(1, 1, 1, 0));
        wr(2, 1, 32'd9);
        wr(2, 3, 32'd12);
        wr(2, 0, ctrl_word(1, 2, 0, 0));
        repeat (6) step();
        check_val("prerst_irq", 32'(irq), 32'd1);
        check_val("prerst_pwm", 32'(pwm_out), 32'b100);
        #2 RSTN = 1'b0;
        @(posedge clk);
        #1 RSTN = 1'b1;
        step();
        check_val("rst_rdata", rdata, 32'd0);
        check_val("rst_irq", 32'(irq), 32'd0);
        check_val("rst_pwm", 32'(pwm_out), 32'd0);
        rd(0, 0, v); check_val("rst_ctrl0", v, 32'd0);
        rd(0, 1, v); check_val("rst_load0", v, 32'd0);
        rd(0, 2, v); check_val("rst_count0", v, 32'd0);
        rd(2, 3, v); check_val("rst_cmp2", v, 32'd0);
        rd(NUM_CH, 0, v); check_val("rst_status", v, 32'd0);

        // One-shot
        wr(0, 1, 32'd3);
        wr(0, 0, ctrl_word(1, 0, 1, 0));
        repeat (3) step();
        check_val("os_irq_early", 32'(irq), 32'd0);
        step();
        check_val("os_irq", 32'(irq), 32'd1);
        check_val("os_ch_irq", 32'(ch_irq), 32'b001);
        rd(NUM_CH, 0, v); check_val("os_status", v, 32'd1);
        rd(0, 0, v);      check_val("os_ctrl_en_clr", v, 32'h8);
        wr(NUM_CH, 0, 32'd1);
        check_val("os_w1c_irq", 32'(irq), 32'd0);

        // Periodic with prescaler, W1C colliding with a new set
        quiesce();
        wr(1, 1, 32'd2);
        wr(1, 0, ctrl_word(1, 1, 1, 1));
        repeat (7) step();
        check_val("per_flag6", 32'(ch_irq), 32'b010);
        wr(NUM_CH, 0, 32'd2);
        check_val("per_cleared", 32'(ch_irq), 32'b000);
        repeat (3) step();
        check_val("per_not_yet", 32'(ch_irq), 32'b000);
        wr(NUM_CH, 0, 32'd2);
        check_val("per_set_wins", 32'(ch_irq), 32'b010);

        // PWM duty cycle
        quiesce();
        wr(2, 1, 32'd9);
        wr(2, 3, 32'd3);
        wr(2, 0, ctrl_word(1, 2, 0, 0));
        repeat (3) step();
        highs = 0;
        for (int i = 0; i < 20; i++) begin step(); highs += int'(pwm_out[2]); end
        check_val("pwm_duty3", 32'(highs), 32'd6);
        wr(2, 3, 32'd0);
        repeat (2) step();
        highs = 0;
        for (int i = 0; i < 20; i++) begin step(); highs += int'(pwm_out[2]); end
        check_val("pwm_cmp0", 32'(highs), 32'd0);
        wr(2, 3, 32'd12);
        repeat (2) step();
        highs = 0;
        for (int i = 0; i < 20; i++) begin step(); highs += int'(pwm_out[2]); end
        check_val("pwm_cmp12", 32'(highs), 32'd20);

        // COUNT write colliding with the expiry tick; unmapped reads
        quiesce();
        wr(0, 1, 32'd5);
        wr(0, 0, ctrl_word(1, 1, 1, 0));
        repeat (5) step();
        wr(0, 2, 32'd7);
        check_val("col_no_flag", 32'(ch_irq), 32'd0);
        rd(0, 2, v); check_val("col_count", v, 32'd7);
        rd(0, 1, v); check_val("rd_load", v, 32'd5);
        addr = 8'h14;
        #1;
        check_val("unmap_latency", rdata, 32'd5);
        step();
        check_val("unmap_reg5", rdata, 32'd0);
        rd(NUM_CH, 1, v); check_val("unmap_glob1", v, 32'd0);
        rd(5, 0, v);      check_val("unmap_ch5", v, 32'd0);
        rd(0, 4, v);      check_val("cap_idle", v, 32'd0);

`ifdef TIMER_CAPTURE_EN
        // Capture with 3-clock latency
        quiesce();
        wr(0, 1, 32'd100);
        wr(0, 0, ctrl_word(1, 1, 0, 0));
        repeat (50) step();
        cap_in[0] = 1'b1;
        repeat (3) step();
        rd(0, 4, v);      check_val("cap_value", v, 32'd47);
        rd(NUM_CH, 0, v); check_val("cap_flag", v, 32'd1);
        cap_in[0] = 1'b0;
`endif

        // Randomized single-channel runs
        for (int it = 0; it < 25; it++) begin
            int ch, mode, ld, p, cmp, ie, tmax;
            logic [31:0] exp_bit;
            ch   = int'($urandom_range(NUM_CH - 1, 0));
            mode = int'($urandom_range(3, 0));
            ld   = int'($urandom_range(12, 0));
            p    = int'($urandom_range(3, 0));
            cmp  = int'($urandom_range(14, 0));
            ie   = int'($urandom_range(1, 0));
            tmax = int'($urandom_range(60, 5));
            exp_bit = 32'(1) << ch;
            quiesce();
            wr(ch, 1, 32'(ld));
            wr(ch, 3, 32'(cmp));
            wr(ch, 0, ctrl_word(1, mode, ie, p));
            addr = ra(ch, 2);
            for (int t = 1; t <= tmax; t++) begin
                step();
                check_val("rnd_count", rdata, 32'(m_count(t - 1, mode, ld, p)));
                check_val("rnd_pwm", 32'(pwm_out), m_pwm(t, mode, ld, p, cmp) ? exp_bit : 32'd0);
                check_val("rnd_ch_irq", 32'(ch_irq),
                          (m_flag(t, mode, ld, p) && ie != 0) ? exp_bit : 32'd0);
            end
            rd(NUM_CH, 0, v);
            check_val("rnd_status", v, m_flag(tmax, mode, ld, p) ? exp_bit : 32'd0);
            rd(ch, 0, v);
            check_val("rnd_ctrl", v, ctrl_word(int'(m_en(tmax + 1, mode, ld, p)), mode, ie, p));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
